// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Stall/flush scheduler for a 5-stage MIPS pipeline.
//
//   The block keeps a small scoreboard of the GPR writers in flight in the
//   E and M stages, each with its remaining Tnew. It compares that scoreboard
//   against the Tuse of the D-stage sources. It stalls D (and bubbles E) when
//   forwarding cannot deliver a value in time.
//
//   It also sequences the multi-cycle mult/div unit. While the unit is busy,
//   any D-stage HI/LO user is held.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   d_rs / d_rt             D-stage source register addresses
//   d_rs_used / d_rt_used   the D instruction actually reads that source
//   d_rs_tuse / d_rt_tuse   cycles until the source is consumed (0 = D, 1 = E, 2 = M)
//   d_wa, d_tnew            D instruction's GPR destination and its Tnew on entering E
//   d_md_start, d_md_div    D instruction starts a mult (div=0) or a div (div=1)
//   d_md_use                D instruction touches HI/LO or starts the md unit
//   stall                   freeze PC and the F/D register
//   flush_e                 load a bubble into the D/E register (same as stall)
//   md_busy                 mult/div unit occupied
//   e_wa, e_tnew            scoreboard entry for the E stage
//   m_wa, m_tnew            scoreboard entry for the M stage
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CW          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_rs_used,
    input  logic       d_rt_used,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic       flush_e,
    output logic       md_busy,
    output logic [4:0] e_wa,
    output logic [1:0] e_tnew,
    output logic [4:0] m_wa,
    output logic [1:0] m_tnew
);

    logic [4:0]    e_wa_q,   e_wa_d;
    logic [1:0]    e_tnew_q, e_tnew_d;
    logic [4:0]    m_wa_q,   m_wa_d;
    logic [1:0]    m_tnew_q, m_tnew_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    logic hit_rs;
    logic hit_rt;
    logic stall_int;
    logic md_busy_int;

    // A source is blocked when any in-flight writer of the same register
    // will still need more cycles than the consumer can wait.
    // $0 is never a real dependency.
    function automatic logic src_hit(
        input logic [4:0] src,
        input logic       used,
        input logic [1:0] tuse,
        input logic [4:0] ewa,
        input logic [1:0] etn,
        input logic [4:0] mwa,
        input logic [1:0] mtn
    );
        logic e_blk;
        logic m_blk;
        e_blk = (ewa == src) && (etn > tuse);
        m_blk = (mwa == src) && (mtn > tuse);
        return used && (src != 5'd0) && (e_blk || m_blk);
    endfunction

    always_comb begin
        hit_rs = src_hit(d_rs, d_rs_used, d_rs_tuse, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
        hit_rt = src_hit(d_rt, d_rt_used, d_rt_tuse, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
        md_busy_int = (md_cnt_q != '0);
        stall_int   = hit_rs || hit_rt || (d_md_use && md_busy_int);
    end

    always_comb begin
        // M always advances; the producer is one cycle closer to its result.
        m_wa_d   = e_wa_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;

        // A stalled D instruction does not enter E; E gets a bubble instead.
        if (stall_int) begin
            e_wa_d   = 5'd0;
            e_tnew_d = 2'd0;
        end else begin
            e_wa_d   = d_wa;
            e_tnew_d = d_tnew;
        end

        // The counter loads only when the md instruction actually leaves D.
        if (!stall_int && d_md_start) begin
            md_cnt_d = d_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end else begin
            md_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_wa_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            m_wa_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            md_cnt_q <= '0;
        end else begin
            e_wa_q   <= e_wa_d;
            e_tnew_q <= e_tnew_d;
            m_wa_q   <= m_wa_d;
            m_tnew_q <= m_tnew_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign stall   = stall_int;
    assign flush_e = stall_int;
    assign md_busy = md_busy_int;
    assign e_wa    = e_wa_q;
    assign e_tnew  = e_tnew_q;
    assign m_wa    = m_wa_q;
    assign m_tnew  = m_tnew_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Directed testbench for hazard_stall_ctrl. A cycle-stamped history of
//   issued instructions predicts the outputs on every cycle. Hand-computed
//   literals pin the key instruction sequences.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wa;
    logic       d_rs_used, d_rt_used;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall, flush_e, md_busy;
    logic [4:0] e_wa, m_wa;
    logic [1:0] e_tnew, m_tnew;

    int checks = 0;
    int errors = 0;
    logic rst_drv = 1'b0;

    hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_wa(d_wa), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .flush_e(flush_e), .md_busy(md_busy),
        .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Key k holds the instruction that entered E on edge k (lives in E during
    // cycle k, in M during cycle k+1, untracked afterwards). Bubbles and
    // reset leave no entry.
    int wa_h[int];
    int tn_h[int];
    int cur = 0;
    int md_end = 0;
    bit mvalid = 1'b0;

    function automatic int remaining(int key, int age);
        int r;
        r = tn_h[key] - age;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit mhit(int s, bit used, int tuse);
        if (!used || s == 0) return 1'b0;
        for (int age = 0; age < 2; age++) begin
            if (wa_h.exists(cur - age))
                if (wa_h[cur - age] == s && remaining(cur - age, age) > tuse) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin : compare
        bit x_busy, x_stall;
        int x_ewa, x_etn, x_mwa, x_mtn;
        x_busy  = (cur < md_end);
        x_stall = mhit(int'(d_rs), d_rs_used, int'(d_rs_tuse)) ||
                  mhit(int'(d_rt), d_rt_used, int'(d_rt_tuse)) ||
                  (d_md_use && x_busy);
        x_ewa = wa_h.exists(cur)     ? wa_h[cur]     : 0;
        x_etn = wa_h.exists(cur)     ? tn_h[cur]     : 0;
        x_mwa = wa_h.exists(cur - 1) ? wa_h[cur - 1] : 0;
        x_mtn = wa_h.exists(cur - 1) ? remaining(cur - 1, 1) : 0;
        if (mvalid) begin
            chk("model_stall",   int'(stall),   int'(x_stall));
            chk("model_flush_e", int'(flush_e), int'(x_stall));
            chk("model_md_busy", int'(md_busy), int'(x_busy));
            chk("model_e_wa",    int'(e_wa),    x_ewa);
            chk("model_e_tnew",  int'(e_tnew),  x_etn);
            chk("model_m_wa",    int'(m_wa),    x_mwa);
            chk("model_m_tnew",  int'(m_tnew),  x_mtn);
        end
        // Advance the model across the coming edge using the inputs now held.
        if (reset) begin
            wa_h.delete();
            tn_h.delete();
            md_end = 0;
            mvalid = 1'b1;
        end else begin
            if (!x_stall) begin
                wa_h[cur + 1] = int'(d_wa);
                tn_h[cur + 1] = int'(d_tnew);
                if (d_md_start) md_end = cur + 1 + (d_md_div ? DIV_N : MULT_N);
            end
        end
        cur++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [4:0] rs, input logic rsu, input logic [1:0] rstu,
                         input logic [4:0] rt, input logic rtu, input logic [1:0] rttu,
                         input logic [4:0] wa, input logic [1:0] tn,
                         input logic ms, input logic md, input logic mu);
        @(posedge clk);
        #1;
        reset = rst_drv;
        d_rs = rs; d_rs_used = rsu; d_rs_tuse = rstu;
        d_rt = rt; d_rt_used = rtu; d_rt_tuse = rttu;
        d_wa = wa; d_tnew = tn;
        d_md_start = ms; d_md_div = md; d_md_use = mu;
        @(negedge clk);
    endtask

    task automatic nop();
        drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic lw(input logic [4:0] wa);
        drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, wa, 2'd2, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic mfx();
        drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic mdstart(input logic div);
        drive(5'd10, 1'b1, 2'd1, 5'd11, 1'b1, 2'd1, 5'd0, 2'd0, 1'b1, div, 1'b1);
    endtask
    task automatic drain();
        repeat (3) nop();
    endtask

    initial begin : main
        int n;
        reset = 1'b1;
        d_rs = 0; d_rt = 0; d_rs_used = 0; d_rt_used = 0; d_rs_tuse = 0; d_rt_tuse = 0;
        d_wa = 0; d_tnew = 0; d_md_start = 0; d_md_div = 0; d_md_use = 0;
        rst_drv = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_stall",   int'(stall),   0);
        chk("reset_md_busy", int'(md_busy), 0);
        chk("reset_e_wa",    int'(e_wa),    0);
        chk("reset_m_tnew",  int'(m_tnew),  0);
        rst_drv = 1'b0;
        drain();

        // lw $1 ; add reads $1 at E
        lw(5'd1);
        chk("lw_add_no_stall_yet", int'(stall), 0);
        drive(5'd1, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("lw_add_stall", int'(stall), 1);
        chk("lw_add_e_wa",  int'(e_wa),  1);
        chk("lw_add_e_tnew", int'(e_tnew), 2);
        drive(5'd1, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("lw_add_release", int'(stall), 0);
        chk("lw_add_bubble_e_wa", int'(e_wa), 0);
        chk("lw_add_m_tnew", int'(m_tnew), 1);
        drain();

        // lw $1 ; beq reads $1 in D -> two stall cycles
        lw(5'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(5'd1, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            if (stall) n++;
            else break;
        end
        chk("lw_beq_stall_cycles", n, 2);
        drain();

        // add $2 ; sw stores $2 (tuse 2) -> no stall
        drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        drive(5'd3, 1'b1, 2'd1, 5'd2, 1'b1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("add_sw_no_stall", int'(stall), 0);
        drain();

        // Both sources hit the same lw: single one-cycle stall
        lw(5'd5);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(5'd5, 1'b1, 2'd1, 5'd5, 1'b1, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
            if (stall) n++;
            else break;
        end
        chk("both_src_stall_cycles", n, 1);
        drain();

        // $0 writer followed by $0 readers never stalls
        drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("zero_reg_no_stall", int'(stall), 0);
        drain();

        // E and M both hold $6: lw $6 ; add $6 ; beq $6
        lw(5'd6);
        drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        drive(5'd6, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("e_and_m_match_stall", int'(stall), 1);
        chk("e_and_m_m_wa", int'(m_wa), 6);
        drain();

        // mult then idle: busy exactly MULT_N cycles
        mdstart(1'b0);
        chk("mult_issue_not_busy", int'(md_busy), 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            nop();
            if (md_busy) n++;
            else break;
        end
        chk("mult_busy_cycles", n, 5);

        // mult then mflo: mflo held MULT_N cycles
        mdstart(1'b0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            mfx();
            if (stall) n++;
            else break;
        end
        chk("mult_mflo_stall_cycles", n, 5);
        drain();

        // Back-to-back mult: the second waits for the first
        mdstart(1'b0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            mdstart(1'b0);
            if (stall) n++;
            else break;
        end
        chk("mult_mult_stall_cycles", n, 5);
        repeat (8) nop();

        // div then mflo: DIV_N stall cycles
        mdstart(1'b1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            mfx();
            if (stall) n++;
            else break;
        end
        chk("div_mflo_stall_cycles", n, 10);
        drain();

        // md start blocked by an rs hazard: counter loads only once it leaves D
        lw(5'd10);
        mdstart(1'b0);
        chk("md_hazard_stall", int'(stall), 1);
        chk("md_hazard_not_busy", int'(md_busy), 0);
        mdstart(1'b0);
        chk("md_hazard_release", int'(stall), 0);
        chk("md_hazard_still_idle", int'(md_busy), 0);
        nop();
        chk("md_hazard_loaded", int'(md_busy), 1);
        repeat (8) nop();

        // Reset while md busy (count 7) and stalled
        mdstart(1'b1);
        repeat (4) mfx();
        chk("pre_reset_stall", int'(stall), 1);
        rst_drv = 1'b1;
        mfx();
        rst_drv = 1'b0;
        mfx();
        chk("post_reset_stall",   int'(stall),   0);
        chk("post_reset_md_busy", int'(md_busy), 0);
        chk("post_reset_e_wa",    int'(e_wa),    0);
        chk("post_reset_e_tnew",  int'(e_tnew),  0);
        chk("post_reset_m_wa",    int'(m_wa),    0);
        chk("post_reset_m_tnew",  int'(m_tnew),  0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
